// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and default slot count for the TDM demultiplexer.
package tdm_pkg;
  typedef enum logic {HUNT, RUN} state_e;
  localparam int NCH_DEFAULT = 4;
endpackage

// File: rtl/slot_counter.sv
// slot_counter: slot index with sync reset, enable, clear-to-1 and wrap at terminal count TC.
module slot_counter #(
  parameter int W = 3,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = clr ? W'(1) : en ? ((cnt_q == TC) ? '0 : cnt_q + W'(1)) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM frame demultiplexer with sync hunting and framing error detection.
// Optional parity slot and par_err output enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     sync,
  input  logic                     din,
  output logic [$clog2(NCH+1)-1:0] sel,
  output logic [NCH-1:0]           dout,
  output logic                     dout_valid,
`ifdef TDM_DEMUX_PARITY_EN
  output logic                     par_err,
`endif
  output logic                     sync_err
);
  localparam int SW = $clog2(NCH+1);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int L = NCH + 1;
`else
  localparam int L = NCH;
`endif
  state_e         state_q, state_d;
  logic [L-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0] dout_q, dout_d;
  logic           dv_q, dv_d, se_q, se_d, frame_ok;
  logic           acc, done;
`ifdef TDM_DEMUX_PARITY_EN
  logic           pe_q, pe_d;
`endif
  // acc: an in-frame data slot (sel > 0) accepted while running
  assign acc  = en & !sync & state_q == RUN & sel != '0;
  assign done = acc & sel == SW'(L-1);
  slot_counter #(.W(SW), .TC(SW'(L-1))) u_cnt (
    .clk(clk),
    .rst(reset),
    .en (acc),
    .clr(en & sync),
    .cnt(sel)
  );
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    se_d     = en & ((sync & sel != '0) | (!sync & state_q == RUN & sel == '0));
    if (en & sync) begin
      state_d     = RUN;
      shadow_d[0] = din;
    end else if (se_d) begin
      state_d = HUNT;
    end else if (acc) begin
      for (int i = 1; i < L; i++) if (sel == SW'(i)) shadow_d[i] = din;
    end
`ifdef TDM_DEMUX_PARITY_EN
    frame_ok = ~^shadow_d;
    pe_d     = done & !frame_ok;
`else
    frame_ok = 1'b1;
`endif
    dv_d   = done & frame_ok;
    dout_d = dv_d ? shadow_d[NCH-1:0] : dout_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      se_q     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      pe_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      se_q     <= se_d;
`ifdef TDM_DEMUX_PARITY_EN
      pe_q     <= pe_d;
`endif
    end
  end
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign sync_err   = se_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err    = pe_q;
`endif
endmodule
